// File: rtl/greenflow_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : greenflow_dbg_pkg
//  Description : Shared constants and state encodings for the GreenFlow debug
//                UART receiver and its command parser.
//  Revision    : 1.0 - initial release
// ============================================================================
package greenflow_dbg_pkg;

    // Status codes reported by the debug transmitter
    localparam logic [1:0] ST_NORMAL  = 2'b00;
    localparam logic [1:0] ST_CLAMP   = 2'b01;
    localparam logic [1:0] ST_THERMAL = 2'b10;
    localparam logic [1:0] ST_FAULT   = 2'b11;

    // Command frame characters
    localparam logic [7:0] CH_HDR = 8'h21; // '!'
    localparam logic [7:0] CH_N   = 8'h4E;
    localparam logic [7:0] CH_C   = 8'h43;
    localparam logic [7:0] CH_T   = 8'h54;
    localparam logic [7:0] CH_F   = 8'h46;
    localparam logic [7:0] CH_R   = 8'h52;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_RECOVER = 3'd4
    } rx_state_e;

    typedef enum logic [0:0] {
        P_IDLE = 1'b0,
        P_HDR  = 1'b1
    } p_state_e;

    // Map a command byte to {hit, status code}; hit=0 for non-force bytes.
    function automatic logic [2:0] decode_force_cmd(input logic [7:0] ch);
        logic [2:0] res;
        res = {1'b0, ST_NORMAL};
        case (ch)
            CH_N:    res = {1'b1, ST_NORMAL};
            CH_C:    res = {1'b1, ST_CLAMP};
            CH_T:    res = {1'b1, ST_THERMAL};
            CH_F:    res = {1'b1, ST_FAULT};
            default: res = {1'b0, ST_NORMAL};
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_debug_rx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : uart_debug_rx_if
//  Description : Serial input plus decoded byte/command outputs of the debug
//                UART receiver. slave = receiver, master = host/observer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_debug_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       force_en;
    logic [1:0] force_code;
    logic       cmd_ack;
    logic       cmd_err;

    modport master (
        output rx,
        input  rx_data, rx_valid, frame_err, force_en, force_code, cmd_ack, cmd_err
    );

    modport slave (
        input  rx,
        output rx_data, rx_valid, frame_err, force_en, force_code, cmd_ack, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 2-FF synchronizer plus 8N1 receive state machine. Samples
//                every bit at its centre; a low stop bit raises frame_err and
//                the line must return high before a new start is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import greenflow_dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       rx_i,
    output logic [7:0]      rx_data_o,
    output logic            rx_valid_o,
    output logic            frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] c_FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE    = RX_IDLE;
    localparam logic [2:0] S_START   = RX_START;
    localparam logic [2:0] S_DATA    = RX_DATA;
    localparam logic [2:0] S_STOP    = RX_STOP;
    localparam logic [2:0] S_RECOVER = RX_RECOVER;

    logic          rx_meta_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    // Bring the asynchronous line into the clock domain; idle level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: half-bit start qualification, then full-bit sampling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == c_HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == c_FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == c_FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                // A held break stays here so it cannot be mistaken for a start
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_debug_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_rx
//  Description : GreenFlow debug UART receive end. '!' + command byte frames
//                force or release the 2-bit status code; stray bytes, framing
//                errors and stalled frames are rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_debug_rx
    import greenflow_dbg_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 20
) (
    input wire logic       clk,
    input wire logic       rst_n,
    uart_debug_rx_if.slave dbg
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] c_TMO_M1 = TW'(TIMEOUT_CLKS - 1);

    localparam logic [0:0] S_P_IDLE = P_IDLE;
    localparam logic [0:0] S_P_HDR  = P_HDR;

    generate
        if (CLKS_PER_BIT < 4) begin : g_cfg_check
            $error("uart_debug_rx: CLK_FREQ_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_frame_err;
    logic [2:0] w_cmd;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (dbg.rx),
        .rx_data_o   (w_rx_data),
        .rx_valid_o  (w_rx_valid),
        .frame_err_o (w_frame_err)
    );

    logic [0:0]    p_state_q, p_state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          en_q, en_d;
    logic [1:0]    code_q, code_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    assign w_cmd = decode_force_cmd(w_rx_data);

    // Parser next state: a received byte always wins over a same-cycle timeout
    always_comb begin
        p_state_d = p_state_q;
        tcnt_d    = '0;
        en_d      = en_q;
        code_d    = code_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        case (p_state_q)
            S_P_IDLE: begin
                if (w_rx_valid && w_rx_data == CH_HDR) p_state_d = S_P_HDR;
            end
            S_P_HDR: begin
                if (w_rx_valid) begin
                    p_state_d = S_P_IDLE;
                    if (w_cmd[2]) begin
                        en_d   = 1'b1;
                        code_d = w_cmd[1:0];
                        ack_d  = 1'b1;
                    end else if (w_rx_data == CH_R) begin
                        en_d   = 1'b0;
                        code_d = ST_NORMAL;
                        ack_d  = 1'b1;
                    end else if (w_rx_data == CH_HDR) begin
                        p_state_d = S_P_HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (w_frame_err || tcnt_q == c_TMO_M1) begin
                    err_d     = 1'b1;
                    p_state_d = S_P_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: p_state_d = S_P_IDLE;
        endcase
    end

    // Parser registers; force state is only ever written alongside cmd_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q <= S_P_IDLE;
            tcnt_q    <= '0;
            en_q      <= 1'b0;
            code_q    <= ST_NORMAL;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            tcnt_q    <= tcnt_d;
            en_q      <= en_d;
            code_q    <= code_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign dbg.rx_data    = w_rx_data;
    assign dbg.rx_valid   = w_rx_valid;
    assign dbg.frame_err  = w_frame_err;
    assign dbg.force_en   = en_q;
    assign dbg.force_code = code_q;
    assign dbg.cmd_ack    = ack_q;
    assign dbg.cmd_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_debug_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_debug_rx
//  Description : Scoreboard bench for uart_debug_rx at 16 clk/bit. Stimulus
//                queues the expected output events; a monitor pops and
//                compares each event the DUT raises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_debug_rx;

    localparam int CPB = 16;
    localparam int K_VALID = 0, K_FERR = 1, K_ACK = 2, K_ERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       en;
        logic [1:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   valid_cyc = 0;
    exp_t sb[$];

    uart_debug_rx_if bus ();

    uart_debug_rx #(
        .CLK_FREQ_HZ  (1_600_000),
        .BAUD         (100_000),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbg   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_evt(input int kind, input logic [7:0] data,
                              input logic en, input logic [1:0] code);
        exp_t e;
        e.kind = kind; e.data = data; e.en = en; e.code = code;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        exp_t e;
        logic ok;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d data=%h at cycle %0d, required none",
                     kind, bus.rx_data, cyc);
            return;
        end
        e  = sb.pop_front();
        ok = (e.kind == kind);
        if (ok && kind == K_VALID) ok = (bus.rx_data == e.data);
        if (ok && (kind == K_ACK || kind == K_ERR))
            ok = (bus.force_en == e.en) && (bus.force_code == e.code);
        if (!ok) begin
            n_fail++;
            $display("FAIL event: got kind=%0d data=%h en=%b code=%b, required kind=%0d data=%h en=%b code=%b",
                     kind, bus.rx_data, bus.force_en, bus.force_code,
                     e.kind, e.data, e.en, e.code);
        end
    endtask

    // Monitor: every pulse the DUT raises must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid) begin
                valid_cyc = cyc;
                check_evt(K_VALID);
            end
            if (bus.frame_err) check_evt(K_FERR);
            if (bus.cmd_ack)   check_evt(K_ACK);
            if (bus.cmd_err)   check_evt(K_ERR);
        end
    end

    task automatic bit_period(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 8N1 byte; stop_low > 0 holds the stop bit low for that many bit periods
    task automatic send_byte(input logic [7:0] b, input int stop_low);
        bit_period(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_period(b[i], CPB);
        if (stop_low > 0) bit_period(1'b0, CPB * stop_low);
        bit_period(1'b1, CPB);
    endtask

    task automatic idle(input int n);
        bit_period(1'b1, n);
    endtask

    task automatic check_reset_state(input string name);
        n_checks++;
        if (bus.rx_data !== 8'h00 || bus.force_en !== 1'b0 || bus.force_code !== 2'b00 ||
            bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
            bus.cmd_ack !== 1'b0 || bus.cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got data=%h en=%b code=%b valid=%b ferr=%b ack=%b err=%b, required all zero",
                     name, bus.rx_data, bus.force_en, bus.force_code, bus.rx_valid,
                     bus.frame_err, bus.cmd_ack, bus.cmd_err);
        end
    endtask

    initial begin
        int start_cyc;
        bus.rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        rst_n = 1'b1;
        idle(10);

        // Plain byte and its latency from the start edge
        expect_evt(K_VALID, 8'h55, 1'b0, 2'b00);
        start_cyc = cyc;
        send_byte(8'h55, 0);
        idle(10);
        n_checks++;
        if (valid_cyc - start_cyc < 153 || valid_cyc - start_cyc > 157) begin
            n_fail++;
            $display("FAIL latency: got %0d clk, required 153..157", valid_cyc - start_cyc);
        end

        // '!','T' back-to-back -> force thermal
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_VALID, 8'h54, 1'b0, 2'b00);
        expect_evt(K_ACK,   8'h00, 1'b1, 2'b10);
        send_byte(8'h21, 0);
        send_byte(8'h54, 0);
        idle(10);

        // '!','X' -> rejected, force held
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_VALID, 8'h58, 1'b0, 2'b00);
        expect_evt(K_ERR,   8'h00, 1'b1, 2'b10);
        send_byte(8'h21, 0);
        send_byte(8'h58, 0);
        idle(10);

        // '!','R' -> release
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_VALID, 8'h52, 1'b0, 2'b00);
        expect_evt(K_ACK,   8'h00, 1'b0, 2'b00);
        send_byte(8'h21, 0);
        send_byte(8'h52, 0);
        idle(10);

        // Lone 'C' is ignored by the parser
        expect_evt(K_VALID, 8'h43, 1'b0, 2'b00);
        send_byte(8'h43, 0);
        idle(20);

        // '!' then silence -> timeout error, then '!','F'
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_ERR,   8'h00, 1'b0, 2'b00);
        send_byte(8'h21, 0);
        idle(340);
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_VALID, 8'h46, 1'b0, 2'b00);
        expect_evt(K_ACK,   8'h00, 1'b1, 2'b11);
        send_byte(8'h21, 0);
        send_byte(8'h46, 0);
        idle(10);

        // Broken stop bit with parser idle: frame_err only
        expect_evt(K_FERR, 8'h00, 1'b0, 2'b00);
        send_byte(8'hA5, 3);
        idle(20);

        // Next '!' received normally, then left to time out
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_ERR,   8'h00, 1'b1, 2'b11);
        send_byte(8'h21, 0);
        idle(400);

        // Framing error inside a frame -> one cmd_err, force kept
        expect_evt(K_VALID, 8'h21, 1'b0, 2'b00);
        expect_evt(K_FERR,  8'h00, 1'b0, 2'b00);
        expect_evt(K_ERR,   8'h00, 1'b1, 2'b11);
        send_byte(8'h21, 0);
        send_byte(8'h4E, 1);
        idle(30);

        // Short glitch produces nothing
        bit_period(1'b0, 4);
        idle(60);

        // Reset mid-byte
        bit_period(1'b0, 2 * CPB + 5);
        rst_n = 1'b0;
        bus.rx = 1'b1;
        #2;
        check_reset_state("reset_mid_byte");
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        check_reset_state("after_reset_release");
        expect_evt(K_VALID, 8'h3C, 1'b0, 2'b00);
        send_byte(8'h3C, 0);
        idle(20);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d events still pending, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
